snax_shell_launch_ctrl: RTL and testbench
=========================================

# snax_shell_launch_ctrl

Parametrised launch/completion controller for SNAX accelerator shells with any number of sub-units, such as a GEMM core followed by a rescale SIMD stage. It sits between the CSR manager and the sub-unit control ports. It latches one configuration, launches only the sub-units selected by a CSR enable mask, waits until every enabled unit has accepted and then finished, and publishes status, a cycle counter and a completion count as read-only CSRs. It generalises the single bypass-bit GEMM/SIMD handshake to N units with independent accept timing.

## Interface
- NumUnits, default 2: number of launchable sub-units (1..16).
- RegRWCount, default 19: number of RW CSRs forwarded to units.
- RegROCount, default 3: number of RO CSRs; fixed layout, must be 3.
- RegDataWidth, default 32: CSR width.
- EnableRegIdx, default 17: RW CSR index holding the unit-enable mask in bits [NumUnits-1:0].

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- csr_reg_set_i  in  RegRWCount×RegDataWidth  configuration from CSR manager.
- csr_reg_set_valid_i  in  1  configuration valid.
- csr_reg_set_ready_o  out  1  configuration accepted.
- csr_reg_ro_set_o  out  RegROCount×RegDataWidth  RO CSRs.
- cfg_o  out  RegRWCount×RegDataWidth  latched configuration, stable from launch until next acceptance.
- unit_ctrl_valid_o  out  NumUnits  per-unit launch request.
- unit_ctrl_ready_i  in  NumUnits  per-unit launch accept.
- unit_busy_i  in  NumUnits  per-unit busy.

## Operation
- States: IDLE, LAUNCH, RUN.
- IDLE: csr_reg_set_ready_o=1.
  - On valid&ready: latch csr_reg_set_i into cfg_o, latch mask = csr_reg_set_i[EnableRegIdx][NumUnits-1:0], clear the acked flags, clear the cycle counter.
  - Mask ≠0 → LAUNCH.
  - Mask =0 → stay IDLE and increment the completion count; no unit is launched.
- LAUNCH: unit_ctrl_valid_o[i] = mask[i] & ~acked[i].
  - A handshake valid&ready on unit i sets acked[i].
  - When (acked | this-cycle handshakes) covers mask → RUN.
  - Units may accept in any cycle, in any order, including all in one cycle.
- RUN: the first RUN cycle is a settle cycle and busy is not sampled. Units must raise unit_busy_i no later than the cycle after their handshake.
  - From the second RUN cycle: if (unit_busy_i & mask)==0 → IDLE and increment the completion count.
- csr_reg_set_ready_o=0 in LAUNCH and RUN; only one configuration is outstanding at a time.
- Busy inputs of masked-off units are ignored everywhere.
- RO CSR layout:
  - ro[0]: bit0 = (state≠IDLE); bits[NumUnits:1] = unit_busy_i & mask; all other bits 0.
  - ro[1]: cycle counter. Increments every cycle state≠IDLE and saturates at all-ones. Holds its value in IDLE until the next acceptance.
  - ro[2]: completion count, wraps modulo 2^RegDataWidth.

## Timing
- Reset values: state IDLE, cfg_o 0, mask 0, acked 0, unit_ctrl_valid_o 0, both counters 0. csr_reg_set_ready_o=1 in IDLE and is therefore 1 out of reset.
- Acceptance at cycle T:
  - cfg_o and unit_ctrl_valid_o are valid from T+1.
  - The earliest RUN is T+2 (all units ready at T+1).
  - The earliest IDLE is T+4, with the completion count incremented at that edge; ro[1] then reads 3.
- unit_ctrl_valid_o[i] is registered-state based. It never depends combinationally on unit_ctrl_ready_i, and once raised it stays high until the handshake.
- Zero-mask acceptance at T: completion count +1 at T+1, ro[1]=0, ready stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately. Units see valid drop asynchronously; a half-launched unit is the caller's responsibility.
- Status ro[0] is combinational from state/mask/unit_busy_i.

## Structure
- Package snax_shell_pkg holds:
  - the state enum (IDLE/LAUNCH/RUN);
  - the RO index localparams (STATUS=0, CYCLES=1, DONES=2);
  - the status bit positions.
- Sub-module snax_sat_counter (width parameter; clear, enable, saturate-or-wrap mode) is instantiated twice, for the cycle counter and the completion count.

## Test plan
- NumUnits=2, mask=2'b11, both ready at T+1, busy for 10 cycles → valid high one cycle each, RUN at T+2, IDLE at T+13, ro[2]=1, ro[1]=12.
- mask=2'b11, unit0 ready at T+1, unit1 ready at T+5 → valid0 drops at T+2, valid1 held T+1..T+5, RUN at T+6.
- mask=2'b01 while unit1 busy the whole time → unit1 never sees valid, completion depends only on unit0, ro[0] bit2=0.
- mask=0 → ready stays 1, no valid, ro[2] increments by 1, ro[1]=0; back-to-back zero-mask configurations count every cycle.
- Preload the cycle counter near all-ones via a long run (force) → holds at 32'hFFFF_FFFF; completion count at max wraps to 0.
- rst_ni low in LAUNCH with valid0 pending → valid0=0, ready=1, counters 0 immediately; a new configuration after release launches normally.

Source files
------------

// File: rtl/snax_shell_pkg.sv
// Shared types and constants for the SNAX shell launch controller.
package snax_shell_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2
   } state_e;

   // RO CSR indices
   localparam int unsigned STATUS = 0;
   localparam int unsigned CYCLES = 1;
   localparam int unsigned DONES  = 2;

   // Status word layout: active flag, then one busy bit per unit
   localparam int unsigned STATUS_ACTIVE_BIT = 0;
   localparam int unsigned STATUS_BUSY_LSB   = 1;

endpackage

// File: rtl/snax_sat_counter.sv
// Up-counter with synchronous clear; saturates at all-ones or wraps, by parameter.
module snax_sat_counter #(
   parameter int unsigned Width    = 32,
   parameter bit          Saturate = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && !(Saturate && (&count_q)))
         count_d = count_q + Width'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/snax_shell_launch_ctrl.sv
// Launch/completion controller: latches one config, launches the masked sub-units,
// waits for all of them to accept and finish, and reports status/cycles/completions.
module snax_shell_launch_ctrl
   import snax_shell_pkg::*;
#(
   parameter int unsigned NumUnits     = 2,
   parameter int unsigned RegRWCount   = 19,
   parameter int unsigned RegROCount   = 3,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned EnableRegIdx = 17
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i,
   input  logic                                   csr_reg_set_valid_i,
   output logic                                   csr_reg_set_ready_o,
   output logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o,
   output logic [RegRWCount-1:0][RegDataWidth-1:0] cfg_o,
   output logic [NumUnits-1:0]                    unit_ctrl_valid_o,
   input  logic [NumUnits-1:0]                    unit_ctrl_ready_i,
   input  logic [NumUnits-1:0]                    unit_busy_i
);

   state_e                                 state;
   logic [RegRWCount-1:0][RegDataWidth-1:0] cfg;
   logic [NumUnits-1:0]                    mask, acked, hs, new_mask, busy_masked;
   logic                                   settled;
   logic                                   accept, all_acked, run_done, done_pulse;
   logic [RegDataWidth-1:0]                status, cycles, dones;

   assign new_mask    = csr_reg_set_i[EnableRegIdx][NumUnits-1:0];
   assign accept      = csr_reg_set_valid_i && (state == IDLE);
   assign busy_masked = unit_busy_i & mask;

   // Valid is a function of registered state only; ready never feeds back into it.
   assign unit_ctrl_valid_o = (state == LAUNCH) ? (mask & ~acked) : '0;
   assign hs                = unit_ctrl_valid_o & unit_ctrl_ready_i;
   assign all_acked         = (((acked | hs) & mask) == mask);

   // First RUN cycle is a settle cycle so units have time to raise busy.
   assign run_done   = (state == RUN) && settled && (busy_masked == '0);
   assign done_pulse = (accept && (new_mask == '0)) || run_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         cfg     <= '0;
         mask    <= '0;
         acked   <= '0;
         settled <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cfg   <= csr_reg_set_i;
                  mask  <= new_mask;
                  acked <= '0;
                  if (new_mask != '0) state <= LAUNCH;
               end
            end
            LAUNCH: begin
               acked <= acked | hs;
               if (all_acked) begin
                  state   <= RUN;
                  settled <= 1'b0;
               end
            end
            RUN: begin
               settled <= 1'b1;
               if (run_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   snax_sat_counter #(.Width(RegDataWidth), .Saturate(1'b1)) u_cycle_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (accept),
      .en    (state != IDLE),
      .count (cycles)
   );

   snax_sat_counter #(.Width(RegDataWidth), .Saturate(1'b0)) u_done_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (1'b0),
      .en    (done_pulse),
      .count (dones)
   );

   always_comb begin
      status                                    = '0;
      status[STATUS_ACTIVE_BIT]                 = (state != IDLE);
      status[STATUS_BUSY_LSB +: NumUnits]       = busy_masked;
   end

   assign csr_reg_set_ready_o      = (state == IDLE);
   assign cfg_o                    = cfg;
   assign csr_reg_ro_set_o[STATUS] = status;
   assign csr_reg_ro_set_o[CYCLES] = cycles;
   assign csr_reg_ro_set_o[DONES]  = dones;

endmodule

// File: tb/tb_snax_shell_launch_ctrl.sv
// Directed bench for snax_shell_launch_ctrl with hand-computed cycle timing.
module tb_snax_shell_launch_ctrl;

   logic              clk, rst_n;
   logic [18:0][31:0] csr;
   logic              csr_valid, csr_ready;
   logic [2:0][31:0]  ro;
   logic [18:0][31:0] cfg;
   logic [1:0]        uvalid, uready, ubusy;

   int total = 0;
   int bad   = 0;

   snax_shell_launch_ctrl dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .csr_reg_set_i       (csr),
      .csr_reg_set_valid_i (csr_valid),
      .csr_reg_set_ready_o (csr_ready),
      .csr_reg_ro_set_o    (ro),
      .cfg_o               (cfg),
      .unit_ctrl_valid_o   (uvalid),
      .unit_ctrl_ready_i   (uready),
      .unit_busy_i         (ubusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [31:0] en);
      for (int k = 0; k < 19; k++) csr[k] = 32'hC0DE_0000 + 32'(k);
      csr[17] = en;
   endtask

   initial begin
      rst_n = 1'b0; csr = '0; csr_valid = 1'b0; uready = '0; ubusy = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", csr_ready, 1);
      chk("rst_valid", uvalid, 0);
      chk("rst_ro0", ro[0], 0);
      chk("rst_ro1", ro[1], 0);
      chk("rst_ro2", ro[2], 0);
      chk("rst_cfg", cfg[5], 0);
      rst_n = 1'b1;
      cyc();

      // T1: mask=11, both accept at T+1, busy T+2..T+11
      load_cfg(32'd3); csr_valid = 1'b1;
      #1 chk("t1_ready", csr_ready, 1);
      cyc();                                      // T+1
      csr_valid = 1'b0; csr = '0; uready = 2'b11;
      #1;
      chk("t1_valid", uvalid, 2'b11);
      chk("t1_cfg5", cfg[5], 32'hC0DE_0005);
      chk("t1_cfg17", cfg[17], 3);
      chk("t1_busyready", csr_ready, 0);
      cyc();                                      // T+2 RUN settle
      uready = '0; ubusy = 2'b11;
      #1;
      chk("t1_valid_drop", uvalid, 0);
      chk("t1_ro0_run", ro[0], 7);
      for (int i = 0; i < 9; i++) cyc();          // T+3..T+11
      cyc();                                      // T+12
      ubusy = '0;
      #1 chk("t1_ro0_last", ro[0], 1);
      cyc();                                      // T+13
      chk("t1_ro0_idle", ro[0], 0);
      chk("t1_ro1", ro[1], 12);
      chk("t1_ro2", ro[2], 1);
      chk("t1_ready_idle", csr_ready, 1);

      // T2: unit0 accepts at T+1, unit1 at T+5
      load_cfg(32'd3); csr_valid = 1'b1;
      cyc();                                      // T+1
      csr_valid = 1'b0; uready = 2'b01;
      #1 chk("t2_valid_t1", uvalid, 2'b11);
      cyc();                                      // T+2
      uready = 2'b00; ubusy = 2'b01;
      #1 chk("t2_valid_t2", uvalid, 2'b10);
      cyc();                                      // T+3
      chk("t2_valid_t3", uvalid, 2'b10);
      chk("t2_ro0_launch", ro[0], 3);
      cyc();                                      // T+4
      cyc();                                      // T+5
      uready = 2'b10;
      #1 chk("t2_valid_t5", uvalid, 2'b10);
      cyc();                                      // T+6 RUN
      uready = '0; ubusy = 2'b11;
      #1;
      chk("t2_valid_t6", uvalid, 0);
      chk("t2_ro0_t6", ro[0], 7);
      cyc();                                      // T+7
      cyc();                                      // T+8
      ubusy = '0;
      cyc();                                      // T+9
      chk("t2_ro0_idle", ro[0], 0);
      chk("t2_ro1", ro[1], 8);
      chk("t2_ro2", ro[2], 2);

      // T3: mask=01, unit1 busy throughout and must be ignored
      ubusy = 2'b10;
      load_cfg(32'd1); csr_valid = 1'b1;
      cyc();                                      // T+1
      csr_valid = 1'b0; uready = 2'b01;
      #1 chk("t3_valid", uvalid, 2'b01);
      cyc();                                      // T+2
      uready = '0; ubusy = 2'b11;
      #1;
      chk("t3_valid_drop", uvalid, 0);
      chk("t3_ro0_run", ro[0], 3);
      cyc();                                      // T+3
      cyc();                                      // T+4
      ubusy = 2'b10;
      #1 chk("t3_ro0_u1masked", ro[0], 1);
      cyc();                                      // T+5
      chk("t3_ro0_idle", ro[0], 0);
      chk("t3_ro1", ro[1], 4);
      chk("t3_ro2", ro[2], 3);
      ubusy = '0;

      // T4: zero mask (upper enable bits set), back-to-back for 4 cycles
      load_cfg(32'hFFFF_FFFC); csr_valid = 1'b1;
      cyc();
      chk("t4_ro2_first", ro[2], 4);
      chk("t4_ro1", ro[1], 0);
      chk("t4_ready", csr_ready, 1);
      chk("t4_valid", uvalid, 0);
      chk("t4_ro0", ro[0], 0);
      cyc(); cyc(); cyc();
      csr_valid = 1'b0;
      #1 chk("t4_ro2_b2b", ro[2], 7);
      cyc();
      chk("t4_ro2_hold", ro[2], 7);

      // T5: cycle counter saturates, completion counter wraps
      load_cfg(32'd1); csr_valid = 1'b1;
      cyc();                                      // T+1
      csr_valid = 1'b0; uready = 2'b01;
      cyc();                                      // T+2
      uready = '0; ubusy = 2'b01;
      force dut.u_cycle_cnt.count_q = 32'hFFFF_FFFD;
      #1 release dut.u_cycle_cnt.count_q;
      repeat (5) cyc();
      chk("t5_sat_run", ro[1], 32'hFFFF_FFFF);
      ubusy = '0;
      cyc(); cyc();
      chk("t5_sat_idle", ro[1], 32'hFFFF_FFFF);
      chk("t5_ro2", ro[2], 8);
      force dut.u_done_cnt.count_q = 32'hFFFF_FFFF;
      #1 release dut.u_done_cnt.count_q;
      #1 chk("t5_ro2_max", ro[2], 32'hFFFF_FFFF);
      load_cfg(32'd0); csr_valid = 1'b1;
      cyc();
      csr_valid = 1'b0;
      #1;
      chk("t5_wrap", ro[2], 0);
      chk("t5_ro1_clr", ro[1], 0);

      // T6: reset during LAUNCH with unit0 still pending
      load_cfg(32'd3); csr_valid = 1'b1;
      cyc();                                      // T+1
      csr_valid = 1'b0; uready = 2'b10;
      cyc();                                      // T+2
      uready = '0; ubusy = 2'b10;
      #1 chk("t6_pending", uvalid, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", uvalid, 0);
      chk("t6_rst_ready", csr_ready, 1);
      chk("t6_rst_ro1", ro[1], 0);
      chk("t6_rst_ro2", ro[2], 0);
      chk("t6_rst_cfg", cfg[5], 0);
      ubusy = '0;
      cyc();
      rst_n = 1'b1;
      cyc();
      load_cfg(32'd2); csr_valid = 1'b1;
      cyc();                                      // T+1
      csr_valid = 1'b0; uready = 2'b10;
      #1 chk("t6_relaunch", uvalid, 2'b10);
      cyc();                                      // T+2
      uready = '0;
      cyc();                                      // T+3
      cyc();                                      // T+4
      chk("t6_idle", ro[0], 0);
      chk("t6_ro1", ro[1], 3);
      chk("t6_ro2", ro[2], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
